// File: rtl/bus4_pkg.sv
// rtl/bus4_pkg.sv - shared phase encoding and widths for the 4-bit instruction bus
package bus4_pkg;

  localparam int NIBBLE_W = 4;
  localparam int ADDR_W   = 12;

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

endpackage

// File: rtl/bus_phase_gen.sv
// rtl/bus_phase_gen.sv - free-running 8-phase counter with sync and one-hot phase decode
module bus_phase_gen
  import bus4_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  output logic [2:0] phase,
  output logic       sync,
  output logic [7:0] phase_hot
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase <= PH_A1;
    end else begin
      phase <= phase + 3'd1;
    end
  end

  assign sync      = (phase == PH_X3);
  assign phase_hot = 8'(1) << phase;

endmodule

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - initiator for the 4-bit multiplexed instruction bus with host fetch port
// Optional SRC issue in X2/X3 is enabled by defining BUS_INITIATOR_SRC_EN.
module bus_initiator
  import bus4_pkg::*;
#(
  parameter int unsigned CMD_BANK = 0
)
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NIBBLE_W-1:0] data_i,
  output logic [NIBBLE_W-1:0] data_o,
  output logic                data_en,
  output logic                sync,
  output logic                rom_cmd,
  output logic [3:0]          ram_cmd_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_src,
  input  logic [7:0]          req_src_data,
  output logic                rsp_valid,
  output logic [7:0]          rsp_data
);

  localparam logic [1:0] BANK_SEL = CMD_BANK[1:0];

  logic [2:0]        phase;
  logic [7:0]        phase_hot;
  logic              active;
  logic              active_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        rsp_data_next;

  bus_phase_gen u_phase (
    .clock     (clock),
    .reset_n   (reset_n),
    .phase     (phase),
    .sync      (sync),
    .phase_hot (phase_hot)
  );

  assign req_ready = sync;

`ifdef BUS_INITIATOR_SRC_EN
  logic       src_reg;
  logic       src_next;
  logic [7:0] src_data_reg;
  logic [7:0] src_data_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_reg      <= 1'b0;
      src_data_reg <= 8'h00;
    end else begin
      src_reg      <= src_next;
      src_data_reg <= src_data_next;
    end
  end

  always_comb begin
    src_next      = src_reg;
    src_data_next = src_data_reg;
    if (phase_hot[PH_X3] && req_valid) begin
      src_next      = req_src;
      src_data_next = req_src_data;
    end
  end
`else
  logic unused_src;
  assign unused_src = ^{req_src, req_src_data, BANK_SEL};
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active   <= 1'b0;
      addr_reg <= '0;
      rsp_data <= 8'h00;
    end else begin
      active   <= active_next;
      addr_reg <= addr_next;
      rsp_data <= rsp_data_next;
    end
  end

  // A request is only taken at the X3 edge; no valid there means a null cycle follows.
  always_comb begin
    active_next   = active;
    addr_next     = addr_reg;
    rsp_data_next = rsp_data;
    if (phase_hot[PH_X3]) begin
      active_next = req_valid;
      if (req_valid) begin
        addr_next = req_addr;
      end
    end
    if (active && phase_hot[PH_M1]) begin
      rsp_data_next = {data_i, rsp_data[3:0]};
    end
    if (active && phase_hot[PH_M2]) begin
      rsp_data_next = {rsp_data[7:4], data_i};
    end
  end

  always_comb begin
    data_o    = '0;
    data_en   = 1'b0;
    rom_cmd   = 1'b0;
    ram_cmd_n = 4'hF;
    rsp_valid = 1'b0;
    if (active) begin
      case (phase)
        PH_A1: begin
          data_o  = addr_reg[NIBBLE_W-1:0];
          data_en = 1'b1;
        end
        PH_A2: begin
          data_o  = addr_reg[2*NIBBLE_W-1:NIBBLE_W];
          data_en = 1'b1;
        end
        PH_A3: begin
          data_o  = addr_reg[3*NIBBLE_W-1:2*NIBBLE_W];
          data_en = 1'b1;
          rom_cmd = 1'b1;
        end
        PH_X1: rsp_valid = 1'b1;
`ifdef BUS_INITIATOR_SRC_EN
        PH_X2: begin
          if (src_reg) begin
            data_o              = src_data_reg[7:4];
            data_en             = 1'b1;
            rom_cmd             = 1'b1;
            ram_cmd_n[BANK_SEL] = 1'b0;
          end
        end
        PH_X3: begin
          if (src_reg) begin
            data_o  = src_data_reg[3:0];
            data_en = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - directed self-checking bench for bus_initiator with a ROM responder model
module tb_bus_initiator;

  logic        clock;
  logic        reset_n;
  logic [3:0]  data_i;
  logic [3:0]  data_o;
  logic        data_en;
  logic        sync;
  logic        rom_cmd;
  logic [3:0]  ram_cmd_n;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic        req_src;
  logic [7:0]  req_src_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;

  int checks   = 0;
  int failures = 0;

  bus_initiator #(.CMD_BANK(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .data_i       (data_i),
    .data_o       (data_o),
    .data_en      (data_en),
    .sync         (sync),
    .rom_cmd      (rom_cmd),
    .ram_cmd_n    (ram_cmd_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_src      (req_src),
    .req_src_data (req_src_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM responder: tracks phase on its own, latches the address, drives M1/M2 when selected.
  logic [7:0]  rom [0:4095];
  logic [2:0]  rph;
  logic [11:0] ra;
  logic        rom_sel;
  logic [7:0]  rom_byte;
  logic        rom_drive;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rph     <= 3'd0;
      ra      <= 12'h000;
      rom_sel <= 1'b0;
    end else begin
      rph <= rph + 3'd1;
      case (rph)
        3'd0: ra[3:0]  <= data_i;
        3'd1: ra[7:4]  <= data_i;
        3'd2: begin
          ra[11:8] <= data_i;
          rom_sel  <= rom_cmd;
        end
        3'd5: rom_sel <= 1'b0;
        default: ;
      endcase
    end
  end

  assign rom_byte  = rom[ra];
  assign rom_drive = rom_sel && (rph == 3'd3 || rph == 3'd4);
  assign data_i    = data_en ? data_o :
                     rom_drive ? ((rph == 3'd3) ? rom_byte[7:4] : rom_byte[3:0]) : 4'h0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  int cyc;
  int bad;
  int pulses;
  int p1, p2;
  logic [7:0] d1, d2;

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'hEE;
    rom[12'h123] = 8'hA5;
    rom[12'h000] = 8'h12;
    rom[12'h001] = 8'h34;

    reset_n = 1'b0; req_valid = 1'b0; req_addr = 12'h000;
    req_src = 1'b0; req_src_data = 8'h00;
    repeat (5) @(negedge clock);
    #1;
    check("rst_data_en", 16'(data_en), 16'h0);
    check("rst_ram_cmd_n", 16'(ram_cmd_n), 16'hF);
    check("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    check("rst_sync", 16'(sync), 16'h0);
    check("rst_req_ready", 16'(req_ready), 16'h0);
    check("rst_rsp_data", 16'(rsp_data), 16'h00);

    reset_n = 1'b1;
    #1;
    cyc = 1;
    while (!sync && cyc < 20) begin tick(); cyc++; end
    check("first_sync_cycle", 16'(cyc), 16'd8);
    check("x3_req_ready", 16'(req_ready), 16'h1);

    // Single fetch of 0x123
    req_valid = 1'b1; req_addr = 12'h123;
    tick(); req_valid = 1'b0;
    check("a1_data_o", 16'(data_o), 16'h3);
    check("a1_data_en", 16'(data_en), 16'h1);
    check("a1_rom_cmd", 16'(rom_cmd), 16'h0);
    check("a1_req_ready", 16'(req_ready), 16'h0);
    tick();
    check("a2_data_o", 16'(data_o), 16'h2);
    check("a2_rom_cmd", 16'(rom_cmd), 16'h0);
    tick();
    check("a3_data_o", 16'(data_o), 16'h1);
    check("a3_data_en", 16'(data_en), 16'h1);
    check("a3_rom_cmd", 16'(rom_cmd), 16'h1);
    tick();
    check("m1_data_en", 16'(data_en), 16'h0);
    check("m1_rom_cmd", 16'(rom_cmd), 16'h0);
    tick();
    check("m2_data_en", 16'(data_en), 16'h0);
    check("m2_rsp_hi", 16'(rsp_data), 16'hA0);
    check("m2_rsp_valid", 16'(rsp_valid), 16'h0);
    tick();
    check("x1_rsp_valid", 16'(rsp_valid), 16'h1);
    check("x1_rsp_data", 16'(rsp_data), 16'hA5);
    tick();
    check("x2_rsp_valid", 16'(rsp_valid), 16'h0);
    check("x2_data_en", 16'(data_en), 16'h0);
    tick();
    check("x3_sync", 16'(sync), 16'h1);

    // Back-to-back fetches of 0x000 and 0x001
    req_valid = 1'b1; req_addr = 12'h000;
    p1 = -1; p2 = -1; d1 = 8'h00; d2 = 8'h00; pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (rsp_valid) begin
        pulses++;
        if (p1 < 0) begin p1 = i; d1 = rsp_data; end
        else begin p2 = i; d2 = rsp_data; end
      end
      if (sync && i == 8) req_addr = 12'h001;
      if (sync && i == 16) req_valid = 1'b0;
    end
    check("b2b_pulses", 16'(pulses), 16'd2);
    check("b2b_first_at", 16'(p1), 16'd6);
    check("b2b_gap", 16'(p2 - p1), 16'd8);
    check("b2b_data0", 16'(d1), 16'h12);
    check("b2b_data1", 16'(d2), 16'h34);

    // Null cycle
    bad = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (data_en || rom_cmd || rsp_valid || ram_cmd_n != 4'hF) bad++;
    end
    check("null_bus_quiet", 16'(bad), 16'd0);
    check("null_sync", 16'(sync), 16'h1);
    check("null_rsp_hold", 16'(rsp_data), 16'h34);

    // Reset dropped during M1 of a fetch
    req_valid = 1'b1; req_addr = 12'h123;
    repeat (4) tick();
    req_valid = 1'b0;
    check("abort_m1_data_en", 16'(data_en), 16'h0);
    reset_n = 1'b0;
    #1;
    check("abort_data_en", 16'(data_en), 16'h0);
    check("abort_rom_cmd", 16'(rom_cmd), 16'h0);
    check("abort_ram_cmd_n", 16'(ram_cmd_n), 16'hF);
    check("abort_rsp_data", 16'(rsp_data), 16'h00);
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
    pulses = 0;
    cyc = 1;
    if (rsp_valid) pulses++;
    while (!sync && cyc < 20) begin
      tick(); cyc++;
      if (rsp_valid) pulses++;
    end
    check("abort_no_rsp", 16'(pulses), 16'd0);
    check("abort_first_sync", 16'(cyc), 16'd8);
    check("abort_rsp_data_kept", 16'(rsp_data), 16'h00);

    // SRC request (issued only when the feature is built in)
    req_valid = 1'b1; req_addr = 12'h123; req_src = 1'b1; req_src_data = 8'h5C;
    repeat (6) tick();
    req_valid = 1'b0; req_src = 1'b0;
    check("src_x1_rsp_data", 16'(rsp_data), 16'hA5);
    tick();
`ifdef BUS_INITIATOR_SRC_EN
    check("src_x2_data_o", 16'(data_o), 16'h5);
    check("src_x2_data_en", 16'(data_en), 16'h1);
    check("src_x2_ram_cmd_n", 16'(ram_cmd_n), 16'hB);
    check("src_x2_rom_cmd", 16'(rom_cmd), 16'h1);
    tick();
    check("src_x3_data_o", 16'(data_o), 16'hC);
    check("src_x3_data_en", 16'(data_en), 16'h1);
    check("src_x3_ram_cmd_n", 16'(ram_cmd_n), 16'hF);
    check("src_x3_rom_cmd", 16'(rom_cmd), 16'h0);
`else
    check("nosrc_x2_data_en", 16'(data_en), 16'h0);
    check("nosrc_x2_ram_cmd_n", 16'(ram_cmd_n), 16'hF);
    check("nosrc_x2_rom_cmd", 16'(rom_cmd), 16'h0);
    tick();
    check("nosrc_x3_data_en", 16'(data_en), 16'h0);
`endif
    check("src_x3_sync", 16'(sync), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
